dram_cmd_responder: RTL and testbench

- Target-side end of the controller command handshake (cmd_req / cmd / cmd_ack); stands in for the DRAM device or PHY behind the controller FSM.
- Accepts one command at a time and enforces per-command timing latency before acknowledging.
- Tracks the open/closed state and open row of every bank, and flags protocol violations.
- Owns the refresh interval timer that drives the controller's refresh_flag.

---
 rtl/dram_pkg.sv | 26 ++
 rtl/dram_refresh_timer.sv | 38 +++
 rtl/dram_cmd_responder.sv | 155 +++++++++++++++
 tb/tb_dram_cmd_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared encodings for the DRAM command responder.
// Contains the command and error codes, the FSM state type and a small max helper.
package dram_pkg;

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_COL = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_ACT_OPEN   = 2'b01;
    localparam logic [1:0] ERR_COL_CLOSED = 2'b10;
    localparam logic [1:0] ERR_REF_OPEN   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval timer: counts up after each restart, saturates at the
// last count and raises refresh_flag until the next REF completes.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REF_INTERVAL = 1024
) (
    input  logic clk,
    input  logic rst_b,
    input  logic restart,
    output logic refresh_flag
);

    localparam int CNT_W = $clog2(REF_INTERVAL);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_INTERVAL - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_flag;

    // A restart always wins over expiry, even on the cycle the count saturates.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else if (restart) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else if (r_count != LAST) begin
            r_count <= r_count + 1'b1;
            r_flag  <= (r_count == LAST - 1'b1);
        end else begin
            r_flag  <= 1'b1;
        end
    end

    assign refresh_flag = r_flag;

endmodule

// File: rtl/dram_cmd_responder.sv
// Target side of the controller command handshake: times each command,
// tracks bank open state, flags protocol errors and owns the refresh timer.
module dram_cmd_responder
    import dram_pkg::*;
#(
    parameter int NUMBER_OF_BANKS = 8,
    parameter int NUMBER_OF_ROWS  = 128,
    parameter int T_RCD           = 3,
    parameter int T_CL            = 2,
    parameter int T_RP            = 3,
    parameter int T_RFC           = 8,
    parameter int REF_INTERVAL    = 1024
) (
    input  logic                               clk,
    input  logic                               rst_b,
    input  logic                               cmd_req,
    input  logic [1:0]                         cmd,
    input  logic [$clog2(NUMBER_OF_BANKS)-1:0] bank_id,
    input  logic [$clog2(NUMBER_OF_ROWS)-1:0]  row_id,
    output logic                               cmd_ack,
    output logic                               refresh_flag,
    output logic                               busy,
    output logic [NUMBER_OF_BANKS-1:0]         bank_open,
    output logic                               err,
    output logic [1:0]                         err_code
);

    localparam int BANK_W = $clog2(NUMBER_OF_BANKS);
    localparam int ROW_W  = $clog2(NUMBER_OF_ROWS);
    localparam int LAT_W  = $clog2(maxOf(maxOf(T_RCD, T_CL), maxOf(T_RP, T_RFC))) + 1;

    state_t                                r_state;
    state_t                                w_nextState;
    logic [1:0]                            r_latCmd;
    logic [BANK_W-1:0]                     r_latBank;
    logic [ROW_W-1:0]                      r_latRow;
    logic [LAT_W-1:0]                      r_latCnt;
    logic                                  r_firstExec;
    logic [NUMBER_OF_BANKS-1:0]            r_bankOpen;
    logic [NUMBER_OF_BANKS-1:0][ROW_W-1:0] r_openRow;
    logic                                  r_cmdAck;
    logic                                  r_busy;
    logic                                  r_err;
    logic [1:0]                            r_errCode;
    logic                                  w_accept;
    logic                                  w_refDone;
    logic [LAT_W-1:0]                      w_loadLat;
    logic [1:0]                            w_violCode;
    logic                                  w_unused;

    assign w_accept  = (r_state == ST_IDLE) && cmd_req;
    assign w_refDone = (r_state == ST_ACK) && (r_latCmd == CMD_REF);
    // The open-row table has no reader inside this block.
    assign w_unused  = ^r_openRow;

    always_comb begin
        w_loadLat = LAT_W'(T_RCD - 1);
        case (cmd)
            CMD_COL: w_loadLat = LAT_W'(T_CL - 1);
            CMD_REF: w_loadLat = LAT_W'(T_RFC - 1);
            CMD_PRE: w_loadLat = LAT_W'(T_RP - 1);
            default: ;
        endcase
    end

    // Bank state cannot change between acceptance and the first EXEC cycle,
    // so checking the latched command one cycle late sees the same state.
    always_comb begin
        w_violCode = ERR_NONE;
        case (r_latCmd)
            CMD_ACT: if (r_bankOpen[r_latBank])  w_violCode = ERR_ACT_OPEN;
            CMD_COL: if (!r_bankOpen[r_latBank]) w_violCode = ERR_COL_CLOSED;
            CMD_REF: if (|r_bankOpen)            w_violCode = ERR_REF_OPEN;
            default: ;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:    if (cmd_req)          w_nextState = ST_EXEC;
            ST_EXEC:    if (r_latCnt == '0)   w_nextState = ST_ACK;
            ST_ACK:                           w_nextState = ST_RELEASE;
            ST_RELEASE: if (!cmd_req)         w_nextState = ST_IDLE;
            default:                          w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_latCmd    <= CMD_ACT;
            r_latBank   <= '0;
            r_latRow    <= '0;
            r_latCnt    <= '0;
            r_firstExec <= 1'b0;
            r_bankOpen  <= '0;
            r_openRow   <= '0;
            r_cmdAck    <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_errCode   <= ERR_NONE;
        end else begin
            r_cmdAck    <= (w_nextState == ST_ACK);
            r_busy      <= (w_nextState != ST_IDLE);
            r_err       <= 1'b0;
            r_firstExec <= 1'b0;
            if (w_accept) begin
                r_latCmd    <= cmd;
                r_latBank   <= bank_id;
                r_latRow    <= row_id;
                r_latCnt    <= w_loadLat;
                r_firstExec <= 1'b1;
            end else if ((r_state == ST_EXEC) && (r_latCnt != '0)) begin
                r_latCnt <= r_latCnt - 1'b1;
            end
            if (r_firstExec && (w_violCode != ERR_NONE)) begin
                r_err     <= 1'b1;
                r_errCode <= w_violCode;
            end
            // Bank state changes take effect on the edge that leaves ACK.
            if (r_state == ST_ACK) begin
                case (r_latCmd)
                    CMD_ACT: begin
                        r_bankOpen[r_latBank] <= 1'b1;
                        r_openRow[r_latBank]  <= r_latRow;
                    end
                    CMD_PRE: r_bankOpen[r_latBank] <= 1'b0;
                    CMD_REF: r_bankOpen            <= '0;
                    default: ;
                endcase
            end
        end
    end

    dram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_refreshTimer (
        .clk          (clk),
        .rst_b        (rst_b),
        .restart      (w_refDone),
        .refresh_flag (refresh_flag)
    );

    assign cmd_ack   = r_cmdAck;
    assign busy      = r_busy;
    assign bank_open = r_bankOpen;
    assign err       = r_err;
    assign err_code  = r_errCode;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Self-checking bench for dram_cmd_responder: directed protocol steps followed by
// random transactions, compared against a transaction-level model of banks and refresh.
`timescale 1ns/1ps
module tb_dram_cmd_responder;

    localparam int NB   = 8;
    localparam int NR   = 128;
    localparam int TRCD = 3;
    localparam int TCL  = 2;
    localparam int TRP  = 3;
    localparam int TRFC = 8;
    localparam int RI   = 16;

    logic       clk     = 1'b0;
    logic       rst_b   = 1'b1;
    logic       cmd_req = 1'b0;
    logic [1:0] cmd     = 2'b00;
    logic [2:0] bank_id = 3'd0;
    logic [6:0] row_id  = 7'd0;
    logic       cmd_ack;
    logic       refresh_flag;
    logic       busy;
    logic [7:0] bank_open;
    logic       err;
    logic [1:0] err_code;

    dram_cmd_responder #(
        .NUMBER_OF_BANKS (NB),
        .NUMBER_OF_ROWS  (NR),
        .T_RCD           (TRCD),
        .T_CL            (TCL),
        .T_RP            (TRP),
        .T_RFC           (TRFC),
        .REF_INTERVAL    (RI)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .cmd_req      (cmd_req),
        .cmd          (cmd),
        .bank_id      (bank_id),
        .row_id       (row_id),
        .cmd_ack      (cmd_ack),
        .refresh_flag (refresh_flag),
        .busy         (busy),
        .bank_open    (bank_open),
        .err          (err),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    int       passCount = 0;
    int       checkCount = 0;
    int       refAge = 0;
    bit       restartPending = 1'b0;
    bit [7:0] modelOpen = '0;
    bit [1:0] modelErrCode = 2'b00;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Refresh model: edges since the last restart, saturating once the flag is due.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_b || restartPending) refAge = 0;
        else if (refAge < RI - 1)     refAge++;
        restartPending = 1'b0;
        checkOutput("refresh_flag", refresh_flag, 32'(refAge >= RI - 1));
    endtask

    function automatic int latencyOf(input logic [1:0] c);
        case (c)
            2'b00:   return TRCD;
            2'b01:   return TCL;
            2'b10:   return TRFC;
            default: return TRP;
        endcase
    endfunction

    task automatic applyStimulus(input logic [1:0] c, input logic [2:0] b, input logic [6:0] r,
                                 input int holdExtra, input bit scramble);
        int         lat;
        bit         expErr;
        logic [1:0] expCode;
        lat     = latencyOf(c);
        expErr  = 1'b0;
        expCode = 2'b00;
        if (c == 2'b00 && modelOpen[b])    begin expErr = 1'b1; expCode = 2'b01; end
        if (c == 2'b01 && !modelOpen[b])   begin expErr = 1'b1; expCode = 2'b10; end
        if (c == 2'b10 && modelOpen != 0)  begin expErr = 1'b1; expCode = 2'b11; end
        cmd_req = 1'b1;
        cmd     = c;
        bank_id = b;
        row_id  = r;
        tick();
        checkOutput("busy_accept", busy, 1);
        checkOutput("ack_accept", cmd_ack, 0);
        for (int n = 1; n <= lat; n++) begin
            if (scramble) begin
                cmd     = 2'($urandom);
                bank_id = 3'($urandom);
                row_id  = 7'($urandom);
            end
            tick();
            if (n == 1 && expErr) modelErrCode = expCode;
            checkOutput("err_pulse", err, 32'(n == 1 && expErr));
            checkOutput("err_code", err_code, modelErrCode);
            checkOutput("ack_latency", cmd_ack, 32'(n == lat));
            checkOutput("busy_exec", busy, 1);
            checkOutput("bank_open_exec", bank_open, modelOpen);
        end
        case (c)
            2'b00:   modelOpen[b] = 1'b1;
            2'b11:   modelOpen[b] = 1'b0;
            2'b10:   begin modelOpen = '0; restartPending = 1'b1; end
            default: ;
        endcase
        tick();
        checkOutput("ack_width", cmd_ack, 0);
        checkOutput("bank_open_update", bank_open, modelOpen);
        for (int h = 0; h < holdExtra; h++) begin
            tick();
            checkOutput("ack_held_req", cmd_ack, 0);
            checkOutput("busy_held_req", busy, 1);
        end
        cmd_req = 1'b0;
        tick();
        checkOutput("busy_idle", busy, 0);
        checkOutput("err_idle", err, 0);
        checkOutput("bank_open_idle", bank_open, modelOpen);
    endtask

    initial begin
        #2 rst_b = 1'b0;
        #1;
        checkOutput("rst_ack", cmd_ack, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_err_code", err_code, 0);
        checkOutput("rst_bank_open", bank_open, 0);
        checkOutput("rst_refresh", refresh_flag, 0);
        repeat (2) tick();
        rst_b = 1'b1;

        // Idle from reset: the flag must rise on the 15th edge and then stay up.
        repeat (RI + 2) tick();

        applyStimulus(2'b00, 3'd2, 7'd5, 0, 1'b0);
        checkOutput("act_bank2_open", bank_open, 8'b0000_0100);
        applyStimulus(2'b01, 3'd2, 7'd0, 0, 1'b0);
        applyStimulus(2'b11, 3'd2, 7'd0, 0, 1'b0);
        checkOutput("pre_bank2_closed", bank_open, 8'b0000_0000);
        applyStimulus(2'b01, 3'd5, 7'd0, 0, 1'b0);
        checkOutput("col_closed_code", err_code, 2'b10);
        applyStimulus(2'b00, 3'd1, 7'd7, 0, 1'b0);
        applyStimulus(2'b00, 3'd1, 7'd9, 0, 1'b0);
        checkOutput("act_open_code", err_code, 2'b01);
        applyStimulus(2'b11, 3'd4, 7'd0, 0, 1'b0);
        applyStimulus(2'b10, 3'd0, 7'd0, 0, 1'b0);
        checkOutput("ref_open_code", err_code, 2'b11);
        repeat (RI + 2) tick();
        applyStimulus(2'b10, 3'd0, 7'd0, 1, 1'b0);
        applyStimulus(2'b00, 3'd3, 7'd33, 3, 1'b1);
        checkOutput("scramble_bank3", bank_open, 8'b0000_1000);

        // Reset in the middle of an ACT: no ack, everything cleared.
        cmd_req = 1'b1;
        cmd     = 2'b00;
        bank_id = 3'd6;
        row_id  = 7'd9;
        tick();
        tick();
        rst_b = 1'b0;
        #1;
        refAge       = 0;
        modelOpen    = '0;
        modelErrCode = 2'b00;
        checkOutput("midrst_ack", cmd_ack, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_bank_open", bank_open, 0);
        checkOutput("midrst_refresh", refresh_flag, 0);
        checkOutput("midrst_err_code", err_code, 0);
        cmd_req = 1'b0;
        tick();
        rst_b = 1'b1;
        for (int i = 0; i < RI + 2; i++) begin
            tick();
            checkOutput("postrst_ack", cmd_ack, 0);
            checkOutput("postrst_busy", busy, 0);
            checkOutput("postrst_bank_open", bank_open, 0);
        end

        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                          7'($urandom_range(0, 127)), int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
